// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one registered fp16 adder among NREQ requesters; results return tagged with requester ID.
// Optional per-requester grant counters are enabled by defining FP16_ADD_ARB_STATS_EN.
module fp16_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_sum,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy
`ifdef FP16_ADD_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]       stat_sel,
  input  logic                 stat_clr,
  output logic [15:0]          stat_cnt
`endif
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic [IDW:0]       scan_idx;
  logic [IDW-1:0]     scan_k;

  logic               iss_vld_q, iss_vld_d;
  logic [IDW-1:0]     iss_id_q, iss_id_d;
  logic [15:0]        add_a_q, add_a_d;
  logic [15:0]        add_b_q, add_b_d;

  logic [ADD_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [ADD_LAT];

  // Arbitration: scan from the pointer, wrapping, and grant the first valid requester.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    scan_idx  = '0;
    scan_k    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
      scan_k = scan_idx[IDW-1:0];
      if (!hold && !gnt_any && req_valid[scan_k]) begin
        req_ready[scan_k] = 1'b1;
        gnt_id            = scan_k;
        gnt_any           = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    iss_vld_d = gnt_any;
    iss_id_d  = iss_id_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    if (gnt_any) begin
      ptr_d    = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      iss_id_d = gnt_id;
      add_a_d  = req_a[{gnt_id, 4'b0000} +: 16];
      add_b_d  = req_b[{gnt_id, 4'b0000} +: 16];
    end
  end

  // Issue stage: operands held for the adder, tagged with the granted ID.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= iss_vld_d;
      iss_id_q  <= iss_id_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
    end
  end

  // Tag pipeline: mirrors the adder latency, never stalls.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tag_vld_q <= '0;
      for (int s = 0; s < ADD_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= iss_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = tag_vld_q[ADD_LAT-1];
  assign rsp_id    = tag_id_q[ADD_LAT-1];
  assign rsp_data  = add_sum;
  assign busy      = iss_vld_q | (|tag_vld_q);

`ifdef FP16_ADD_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (stat_clr)                            cnt_q[k] <= '0;
        else if (gnt_any && gnt_id == IDW'(k))   cnt_q[k] <= sat_inc(cnt_q[k]);
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt_q[stat_sel] : 16'h0000;
`endif

endmodule

// File: doc/fp16_add_arbiter.md
Name: fp16_add_arbiter

Overview:
- Shares one registered fp16 adder (sum = A + B, output registered on CLK) among NREQ requesters inside the float MAC.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Registers the granted operands into an issue stage, then tracks requester IDs through the adder pipeline.
- Returns each sum tagged with its requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- ADD_LAT, 1, adder latency in cycles: operands on add_a/add_b to valid add_sum.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESETn  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_a  input  16*NREQ  operand A; requester k uses bits [16k+15:16k].
- req_b  input  16*NREQ  operand B, same packing.
- req_ready  output  NREQ  one-hot grant (combinational); a transfer occurs when req_valid[k] & req_ready[k].
- hold  input  1  when 1, no new grants; in-flight operations drain.
- add_a  output  16  issue-stage register to adder A.
- add_b  output  16  issue-stage register to adder B.
- add_sum  input  16  adder result.
- rsp_valid  output  1  add_sum holds a result for rsp_id this cycle.
- rsp_id  output  IDW  requester owning the result.
- rsp_data  output  16  equals add_sum (pass-through).
- busy  output  1  any in-flight operation in the issue stage or tag pipeline.

Behaviour:
- Reset (async assert, sync release): add_a=add_b=0, issue valid=0, all tag stages invalid, rsp_valid=0, rsp_id=0, busy=0, rr pointer=0.
- Arbitration (combinational):
  - Applies when hold=0.
  - Scan indices ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1; grant the first with req_valid=1.
  - req_ready is one-hot or all-zero and never depends on req_a or req_b.
- hold=1 forces req_ready=0. The pointer is unchanged.
- On a transfer:
  - The issue stage loads {valid=1, id=k, a, b} at the clock edge.
  - The pointer becomes (k+1) mod NREQ.
- No transfer: issue valid loads 0; add_a/add_b keep their previous value.
- Tag pipeline:
  - ADD_LAT stages of {valid, id}, shifted every cycle from the issue stage.
  - There is no stall; the adder is never back-pressured.
  - rsp_valid/rsp_id come from the last stage.
- Latency: a transfer at edge T gives rsp_valid=1 in the cycle after edge T+ADD_LAT, i.e. 1+ADD_LAT cycles after acceptance.
- Throughput is one operation per cycle. Results return in acceptance order.
- busy = issue valid OR any tag-stage valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0 with no gaps.
- A single active requester is granted every cycle.
- Simultaneous events:
  - Deasserting req_valid in the cycle a grant would occur cancels that grant; no transfer and no pointer change.
  - hold rising mid-stream: in-flight operations complete normally; busy falls exactly 1+ADD_LAT cycles after the last accept.
- Reset mid-operation: all in-flight tags are discarded immediately; no rsp_valid appears after reset, even though add_sum may change.
- Arithmetic is entirely inside the adder. This block never alters operand or result bits, including the special encodings (NaN 0x7C01, inf 0x7C00 with sign).

Optional Feature:
- Macro FP16_ADD_ARB_STATS_EN.
- Defined:
  - Adds input stat_sel (IDW bits), input stat_clr (1 bit), output stat_cnt (16 bits).
  - One 16-bit grant counter per requester, incremented on each transfer and saturating at 0xFFFF.
  - stat_clr=1 zeroes all counters synchronously; clear wins over a same-cycle increment.
  - stat_cnt = counter[stat_sel], combinational.
  - Counters reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester 0 with a=0x3C00, b=0x4000 (1.0+2.0), ADD_LAT=1 -> req_ready[0]=1 the same cycle; rsp_valid=1, rsp_id=0, rsp_data=0x4200 two cycles later; busy high for exactly 2 cycles.
- All 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical, lagging by 2 cycles; no idle cycle.
- Pointer wrap: last grant 3, then only requesters 1 and 2 valid -> grant 1 then 2, then 1 again.
- hold=1 while requesters 0 and 2 are valid -> req_ready=0; in-flight ops complete, then busy=0. Release hold -> the grant resumes at the saved pointer.
- RESETn low one cycle after accepting an op from requester 2 -> no rsp_valid ever appears; all outputs 0; after release the pointer is 0 and requester 0 wins over requester 3.
- STATS_EN: 5 grants to requester 1, then stat_sel=1 -> stat_cnt=5. stat_clr in the same cycle as a grant -> stat_cnt=0.
